// File: rtl/sram_async_ctrl.sv
// Clocked valid/ready front end for an asynchronous SRAM: sequences cs/we/oe through
// setup, strobe and hold phases with registered strobes and a one-cycle read response.
module sram_async_ctrl #(
   parameter int ADDR_WIDTH       = 8,
   parameter int DATA_WIDTH       = 8,
   parameter int WR_PULSE_CYCLES  = 2,
   parameter int RD_ACCESS_CYCLES = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  rsp_valid_o,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  sram_cs_o,
   output logic                  sram_we_o,
   output logic                  sram_oe_o,
   output logic [ADDR_WIDTH-1:0] sram_addr_o,
   output logic [DATA_WIDTH-1:0] sram_data_o,
   output logic                  sram_data_oe_o,
   input  logic [DATA_WIDTH-1:0] sram_data_i
);

   localparam int MAX_CYC = (WR_PULSE_CYCLES > RD_ACCESS_CYCLES) ? WR_PULSE_CYCLES : RD_ACCESS_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   if (WR_PULSE_CYCLES < 1) begin : g_bad_wr_pulse
      $error("WR_PULSE_CYCLES must be >= 1");
   end
   if (RD_ACCESS_CYCLES < 1) begin : g_bad_rd_access
      $error("RD_ACCESS_CYCLES must be >= 1");
   end

   typedef enum logic [2:0] {
      IDLE,
      W_SETUP,
      W_PULSE,
      W_HOLD,
      R_SETUP,
      R_ACCESS
   } state_e;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  ready_q, ready_d;
   logic                  cs_q, cs_d;
   logic                  we_q, we_d;
   logic                  oe_q, oe_d;
   logic                  doe_q, doe_d;
   logic                  accept;
   logic                  last_cycle;

   // ready_q rather than the state gates acceptance, so nothing is taken before ready is seen high
   assign accept     = req_valid_i && ready_q;
   assign last_cycle = (cnt_q == CNT_W'(1));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: every variable gets a default first so no path through the case infers a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE:     if (accept) state_d = req_we_i ? W_SETUP : R_SETUP;
         W_SETUP: begin
            state_d = W_PULSE;
            cnt_d   = CNT_W'(WR_PULSE_CYCLES);
         end
         W_PULSE: begin
            cnt_d = cnt_q - 1'b1;
            if (last_cycle) state_d = W_HOLD;
         end
         W_HOLD:   state_d = IDLE;
         R_SETUP: begin
            state_d = R_ACCESS;
            cnt_d   = CNT_W'(RD_ACCESS_CYCLES);
         end
         R_ACCESS: begin
            cnt_d = cnt_q - 1'b1;
            if (last_cycle) state_d = IDLE;
         end
         default:  state_d = IDLE;
      endcase
   end

   // Strobes are decoded from the next state and registered, so the pins never see decode glitches.
   always_comb begin
      ready_d     = 1'b0;
      cs_d        = 1'b0;
      we_d        = 1'b0;
      oe_d        = 1'b0;
      doe_d       = 1'b0;
      unique case (state_d)
         IDLE:     ready_d = 1'b1;
         W_SETUP:  begin cs_d = 1'b1; doe_d = 1'b1; end
         W_PULSE:  begin cs_d = 1'b1; we_d = 1'b1; doe_d = 1'b1; end
         W_HOLD:   begin cs_d = 1'b1; doe_d = 1'b1; end
         R_SETUP:  ;
         R_ACCESS: begin cs_d = 1'b1; oe_d = 1'b1; end
         default:  ;
      endcase
      rsp_valid_d = (state_q == R_ACCESS) && last_cycle;
      rdata_d     = rsp_valid_d ? sram_data_i : rdata_q;
   end

   // NOTE: every flop here is reset, so an aborted access drops all strobes without a clock edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ready_q     <= 1'b0;
         cs_q        <= 1'b0;
         we_q        <= 1'b0;
         oe_q        <= 1'b0;
         doe_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
      end else begin
         ready_q     <= ready_d;
         cs_q        <= cs_d;
         we_q        <= we_d;
         oe_q        <= oe_d;
         doe_q       <= doe_d;
         rsp_valid_q <= rsp_valid_d;
         rdata_q     <= rdata_d;
         if (accept) begin
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
         end
      end
   end

   assign req_ready_o    = ready_q;
   assign rsp_valid_o    = rsp_valid_q;
   assign rsp_rdata_o    = rdata_q;
   assign sram_cs_o      = cs_q;
   assign sram_we_o      = we_q;
   assign sram_oe_o      = oe_q;
   assign sram_data_oe_o = doe_q;
   assign sram_addr_o    = addr_q;
   assign sram_data_o    = wdata_q;

endmodule

// File: tb/tb_sram_async_ctrl.sv
// Directed bench for sram_async_ctrl: default instance plus a WR=1/RD=4 instance,
// each attached to a behavioural async SRAM model.
module tb_sram_async_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   // Instance A: default timing
   logic       a_req_valid = 1'b0, a_req_we = 1'b0, a_req_ready, a_rsp_valid;
   logic [7:0] a_req_addr = '0, a_req_wdata = '0, a_rsp_rdata;
   logic       a_cs, a_we, a_oe, a_doe;
   logic [7:0] a_addr, a_dout, a_din;
   logic [7:0] mem_a [256];

   sram_async_ctrl dut_a (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_we_i(a_req_we),
      .req_addr_i(a_req_addr), .req_wdata_i(a_req_wdata),
      .rsp_valid_o(a_rsp_valid), .rsp_rdata_o(a_rsp_rdata),
      .sram_cs_o(a_cs), .sram_we_o(a_we), .sram_oe_o(a_oe),
      .sram_addr_o(a_addr), .sram_data_o(a_dout), .sram_data_oe_o(a_doe),
      .sram_data_i(a_din)
   );

   // Instance B: parameter sweep
   logic       b_req_valid = 1'b0, b_req_we = 1'b0, b_req_ready, b_rsp_valid;
   logic [7:0] b_req_addr = '0, b_req_wdata = '0, b_rsp_rdata;
   logic       b_cs, b_we, b_oe, b_doe;
   logic [7:0] b_addr, b_dout, b_din;
   logic [7:0] mem_b [256];

   sram_async_ctrl #(.WR_PULSE_CYCLES(1), .RD_ACCESS_CYCLES(4)) dut_b (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_we_i(b_req_we),
      .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata),
      .rsp_valid_o(b_rsp_valid), .rsp_rdata_o(b_rsp_rdata),
      .sram_cs_o(b_cs), .sram_we_o(b_we), .sram_oe_o(b_oe),
      .sram_addr_o(b_addr), .sram_data_o(b_dout), .sram_data_oe_o(b_doe),
      .sram_data_i(b_din)
   );

   // Behavioural SRAMs: write while cs&&we, read combinationally while cs&&oe
   initial begin
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = 8'h00;
         mem_b[i] = 8'h00;
      end
   end
   always @(posedge clk) begin
      if (a_cs && a_we) mem_a[a_addr] <= a_dout;
      if (b_cs && b_we) mem_b[b_addr] <= b_dout;
   end
   assign a_din = (a_cs && a_oe) ? mem_a[a_addr] : 8'h00;
   assign b_din = (b_cs && b_oe) ? mem_b[b_addr] : 8'h00;

   // Per-cycle invariants; no cs-high run may exceed the longest single access (4 cycles)
   int run_a = 0, run_b = 0;
   always @(negedge clk) begin
      if (!rst) begin
         run_a = a_cs ? run_a + 1 : 0;
         run_b = b_cs ? run_b + 1 : 0;
         checks++;
         if ((a_we && a_oe) || (a_oe && a_doe) || (a_we && !a_cs) || (a_req_ready && a_cs) || run_a > 4) begin
            errors++;
            $display("FAIL invariant_a t=%0t: we=%b oe=%b doe=%b cs=%b ready=%b cs_run=%0d, required no overlap and cs_run<=4",
                     $time, a_we, a_oe, a_doe, a_cs, a_req_ready, run_a);
         end
         checks++;
         if ((b_we && b_oe) || (b_oe && b_doe) || (b_we && !b_cs) || (b_req_ready && b_cs) || run_b > 4) begin
            errors++;
            $display("FAIL invariant_b t=%0t: we=%b oe=%b doe=%b cs=%b ready=%b cs_run=%0d, required no overlap and cs_run<=4",
                     $time, b_we, b_oe, b_doe, b_cs, b_req_ready, run_b);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic wait_ready_a();
      for (int i = 0; i < 50 && !a_req_ready; i++) begin
         @(posedge clk); #1;
      end
      checks++;
      if (a_req_ready !== 1'b1) begin
         errors++;
         $display("FAIL wait_ready_a: ready=%b, required 1 within 50 cycles", a_req_ready);
      end
   endtask

   task automatic wait_ready_b();
      for (int i = 0; i < 50 && !b_req_ready; i++) begin
         @(posedge clk); #1;
      end
      checks++;
      if (b_req_ready !== 1'b1) begin
         errors++;
         $display("FAIL wait_ready_b: ready=%b, required 1 within 50 cycles", b_req_ready);
      end
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #2;
      checks++;
      if ({a_req_ready, a_rsp_valid, a_rsp_rdata, a_cs, a_we, a_oe, a_doe, a_addr, a_dout} !== '0) begin
         errors++;
         $display("FAIL reset_outputs_a: got %b, required all zero",
                  {a_req_ready, a_rsp_valid, a_rsp_rdata, a_cs, a_we, a_oe, a_doe, a_addr, a_dout});
      end
      checks++;
      if ({b_req_ready, b_rsp_valid, b_rsp_rdata, b_cs, b_we, b_oe, b_doe, b_addr, b_dout} !== '0) begin
         errors++;
         $display("FAIL reset_outputs_b: got %b, required all zero",
                  {b_req_ready, b_rsp_valid, b_rsp_rdata, b_cs, b_we, b_oe, b_doe, b_addr, b_dout});
      end
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      #2;
      checks++;
      if (a_req_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_before_edge: got %b, required 0", a_req_ready);
      end
      @(posedge clk); #1;
      checks++;
      if ({a_req_ready, b_req_ready} !== 2'b11) begin
         errors++;
         $display("FAIL ready_after_release: got %b, required 11", {a_req_ready, b_req_ready});
      end
   endtask

   // Write on instance A; default timing gives W_SETUP, two pulse cycles, W_HOLD
   task automatic test_write(input logic [7:0] ad, input logic [7:0] wd);
      logic [4:0] exp_v, obs_v;
      wait_ready_a();
      a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = ad; a_req_wdata = wd;
      @(posedge clk); #1;
      a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = 8'hFF; a_req_wdata = 8'h00;
      for (int k = 1; k <= 5; k++) begin
         exp_v = {(k <= 4), (k == 2 || k == 3), 1'b0, (k <= 4), (k == 5)};
         obs_v = {a_cs, a_we, a_oe, a_doe, a_req_ready};
         checks++;
         if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL write_strobes T+%0d: {cs,we,oe,doe,ready}=%b, required %b", k, obs_v, exp_v);
         end
         if (k <= 4) begin
            checks++;
            if ({a_addr, a_dout} !== {ad, wd}) begin
               errors++;
               $display("FAIL write_bus T+%0d: addr=%h data=%h, required %h %h", k, a_addr, a_dout, ad, wd);
            end
         end
         if (k < 5) begin
            @(posedge clk); #1;
         end
      end
      checks++;
      if (mem_a[ad] !== wd) begin
         errors++;
         $display("FAIL write_mem: mem[%h]=%h, required %h", ad, mem_a[ad], wd);
      end
   endtask

   // Read on instance A; R_SETUP, two access cycles, response at T+4
   task automatic test_read(input logic [7:0] ad, input logic [7:0] exp_d);
      logic [4:0] exp_v, obs_v;
      wait_ready_a();
      a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = ad;
      @(posedge clk); #1;
      a_req_valid = 1'b0; a_req_addr = ~ad;
      for (int k = 1; k <= 5; k++) begin
         exp_v = {(k == 2 || k == 3), (k == 2 || k == 3), 1'b0, (k == 4), (k >= 4)};
         obs_v = {a_cs, a_oe, a_doe, a_rsp_valid, a_req_ready};
         checks++;
         if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL read_strobes T+%0d: {cs,oe,doe,rsp_valid,ready}=%b, required %b", k, obs_v, exp_v);
         end
         if (k == 4) begin
            checks++;
            if (a_rsp_rdata !== exp_d) begin
               errors++;
               $display("FAIL read_data addr %h: got %h, required %h", ad, a_rsp_rdata, exp_d);
            end
         end
         if (k < 5) begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_reset_mid_write();
      wait_ready_a();
      a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 8'h10; a_req_wdata = 8'h55;
      @(posedge clk); #1;
      a_req_valid = 1'b0; a_req_we = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      checks++;
      if ({a_cs, a_we, a_doe} !== 3'b111) begin
         errors++;
         $display("FAIL mid_write_pulse: {cs,we,doe}=%b, required 111", {a_cs, a_we, a_doe});
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({a_cs, a_we, a_oe, a_doe, a_rsp_valid} !== 5'b0) begin
         errors++;
         $display("FAIL abort_strobes: {cs,we,oe,doe,rsp_valid}=%b, required 00000",
                  {a_cs, a_we, a_oe, a_doe, a_rsp_valid});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({a_rsp_valid, a_cs, a_req_ready} !== 3'b001) begin
         errors++;
         $display("FAIL after_abort: {rsp_valid,cs,ready}=%b, required 001", {a_rsp_valid, a_cs, a_req_ready});
      end
   endtask

   // Alternating write/read stream with valid held high; garbage inputs while busy
   task automatic test_back_to_back();
      logic       op_we [16];
      logic [7:0] op_ad [16];
      logic [7:0] op_wd [16];
      logic [7:0] exp_q [$];
      logic [7:0] exp_d;
      int         idx = 0, nrsp = 0, cyc = 0;
      logic       acc;
      for (int i = 0; i < 16; i += 2) begin
         op_we[i] = 1'b1; op_ad[i] = 8'($urandom); op_wd[i] = 8'($urandom);
         op_we[i+1] = 1'b0; op_ad[i+1] = op_ad[i]; op_wd[i+1] = op_wd[i];
      end
      while ((idx < 16 || nrsp < 8) && cyc < 500) begin
         acc = a_req_ready && (idx < 16);
         if (acc) begin
            a_req_valid = 1'b1; a_req_we = op_we[idx]; a_req_addr = op_ad[idx]; a_req_wdata = op_wd[idx];
         end else begin
            a_req_valid = (idx < 16) || !a_req_ready;
            a_req_we = 1'($urandom); a_req_addr = 8'($urandom); a_req_wdata = 8'($urandom);
         end
         @(posedge clk); #1;
         if (acc) begin
            if (!op_we[idx]) exp_q.push_back(op_wd[idx]);
            idx++;
         end
         if (a_rsp_valid) begin
            nrsp++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL b2b_unexpected_rsp: data=%h, required no response", a_rsp_rdata);
            end else begin
               exp_d = exp_q.pop_front();
               if (a_rsp_rdata !== exp_d) begin
                  errors++;
                  $display("FAIL b2b_read_data #%0d: got %h, required %h", nrsp, a_rsp_rdata, exp_d);
               end
            end
         end
         cyc++;
      end
      a_req_valid = 1'b0;
      checks++;
      if (idx != 16 || nrsp != 8) begin
         errors++;
         $display("FAIL b2b_progress: issued=%0d responses=%0d, required 16 and 8", idx, nrsp);
      end
   endtask

   // Instance B: WR_PULSE_CYCLES=1, RD_ACCESS_CYCLES=4
   task automatic test_param_sweep();
      logic [3:0] exp_v, obs_v;
      wait_ready_b();
      b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 8'h22; b_req_wdata = 8'h99;
      @(posedge clk); #1;
      b_req_valid = 1'b0; b_req_we = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         exp_v = {(k <= 3), (k == 2), (k <= 3), (k >= 4)};
         obs_v = {b_cs, b_we, b_doe, b_req_ready};
         checks++;
         if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL sweep_write T+%0d: {cs,we,doe,ready}=%b, required %b", k, obs_v, exp_v);
         end
         @(posedge clk); #1;
      end
      b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 8'h22;
      @(posedge clk); #1;
      b_req_valid = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         exp_v = {(k >= 2 && k <= 5), (k >= 2 && k <= 5), (k == 6), (k >= 6)};
         obs_v = {b_cs, b_oe, b_rsp_valid, b_req_ready};
         checks++;
         if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL sweep_read T+%0d: {cs,oe,rsp_valid,ready}=%b, required %b", k, obs_v, exp_v);
         end
         if (k == 6) begin
            checks++;
            if (b_rsp_rdata !== 8'h99) begin
               errors++;
               $display("FAIL sweep_read_data: got %h, required 99", b_rsp_rdata);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_write(8'h3C, 8'hA5);
      test_read(8'h3C, 8'hA5);
      test_reset_mid_write();
      test_read(8'h3C, 8'hA5);
      test_back_to_back();
      test_param_sweep();
      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_async_ctrl.md
# sram_async_ctrl

Synchronous controller that sequences one `single_port_async_sram`-style device (chip select, write enable, output enable, address, bidirectional data) from a clocked valid/ready request port. It generates setup, strobe and hold phases with parameterizable wait states. It guarantees that write enable and output enable are never active together, and returns read data on a one-cycle response pulse. The block sits between a synchronous bus master (CPU/DMA on the board) and the external async SRAM pins; the pad-level tristate is built from `sram_data_o`/`sram_data_oe_o`/`sram_data_i`.

## Interface
- `ADDR_WIDTH`, default 8: SRAM address width.
- `DATA_WIDTH`, default 8: SRAM data width.
- `WR_PULSE_CYCLES`, default 2: cycles `sram_we_o` is held high per write. Must be ≥1; elaboration error otherwise.
- `RD_ACCESS_CYCLES`, default 2: cycles `sram_cs_o`/`sram_oe_o` are held high per read. Must be ≥1; elaboration error otherwise.

- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: controller idle, request accepted on valid&&ready.
- `req_we_i` in 1: 1 = write, 0 = read.
- `req_addr_i` in ADDR_WIDTH: access address.
- `req_wdata_i` in DATA_WIDTH: write data.
- `rsp_valid_o` out 1: one-cycle pulse; read data valid. Reads only.
- `rsp_rdata_o` out DATA_WIDTH: registered read data, held until next read response.
- `sram_cs_o` out 1: SRAM chip select.
- `sram_we_o` out 1: SRAM write enable.
- `sram_oe_o` out 1: SRAM output enable.
- `sram_addr_o` out ADDR_WIDTH: SRAM address.
- `sram_data_o` out DATA_WIDTH: data driven to SRAM.
- `sram_data_oe_o` out 1: drive enable for `sram_data_o`.
- `sram_data_i` in DATA_WIDTH: data read from SRAM pins.

## Operation
- FSM states and `sram_*` strobes in each state:
  - IDLE: no strobes; `req_ready_o`=1.
  - W_SETUP: cs=1, we=0, data_oe=1.
  - W_PULSE: cs=1, we=1, data_oe=1.
  - W_HOLD: cs=1, we=0, data_oe=1.
  - R_SETUP: cs=0, oe=0, data_oe=0.
  - R_ACCESS: cs=1, oe=1, data_oe=0.
- Transitions:
  - IDLE, on accept: to W_SETUP if `req_we_i`, else to R_SETUP.
  - W_SETUP → W_PULSE.
  - W_PULSE → W_HOLD after WR_PULSE_CYCLES cycles.
  - W_HOLD → IDLE.
  - R_SETUP → R_ACCESS.
  - R_ACCESS → IDLE after RD_ACCESS_CYCLES cycles.
- One down-counter, width `$clog2(max(WR_PULSE_CYCLES,RD_ACCESS_CYCLES)+1)`, is loaded on entry to W_PULSE/R_ACCESS and decremented each cycle. It exits the state when it reaches 1.
- Address, write data and direction are captured into registers on accept. Request inputs are ignored while not IDLE.
- `sram_addr_o` and `sram_data_o` come from the captured registers and stay stable for the whole access, including setup and hold.
- All `sram_*` outputs come from flops (no combinational decode glitches).
- Invariants, required in every cycle:
  - never we&&oe;
  - never oe&&data_oe;
  - we implies cs.
- On a read, cs and oe rise in the same cycle, with the address already stable one cycle earlier (R_SETUP). This is required because the device samples the address on cs/oe edges.
- cs is low for ≥1 cycle between consecutive accesses (IDLE or R_SETUP).
- Read data: on the last R_ACCESS cycle, `sram_data_i` is registered into `rsp_rdata_o`, and `rsp_valid_o` is asserted for the following cycle.
- No response backpressure.
- Writes produce no response; completion is visible as `req_ready_o` returning high.

## Timing
- Reset values, applied asynchronously on `rst_i`: state IDLE, and all outputs 0, namely:
  - `req_ready_o`, `rsp_valid_o`, `rsp_rdata_o`;
  - `sram_cs_o`, `sram_we_o`, `sram_oe_o`, `sram_data_oe_o`;
  - `sram_addr_o`, `sram_data_o`.
- `req_ready_o` rises in the first cycle after reset release.
- Reset mid-access aborts the access: strobes drop in the same instant, with no clock needed. No response is issued. The SRAM content at the aborted address is undefined.
- Write accepted in cycle T:
  - W_SETUP at T+1;
  - W_PULSE at T+2 .. T+1+W;
  - W_HOLD at T+2+W;
  - IDLE/ready at T+3+W.
  - Occupancy is W+3 cycles.
- Read accepted in cycle T:
  - R_SETUP at T+1;
  - R_ACCESS at T+2 .. T+1+R;
  - `rsp_valid_o` and `req_ready_o` at T+2+R.
  - Occupancy is R+2 cycles.
- Back-to-back: valid held high is accepted in the first IDLE cycle. A new request can be accepted in the same cycle `rsp_valid_o` is high.

## Test plan
- Reset: drive `rst_i`=1 with no clock → all outputs 0. Release → `req_ready_o`=1 on the next edge.
- Write, defaults, addr 0x3C, data 0xA5, accepted at T:
  - we high exactly at T+2..T+3;
  - cs high T+1..T+4;
  - addr=0x3C and data=0xA5 with data_oe=1 at T+1..T+4;
  - ready again at T+5;
  - SRAM model mem[0x3C]=0xA5.
- Read 0x3C after the write:
  - oe and cs rise together at T+2;
  - `rsp_valid_o` is a single pulse at T+4 with `rsp_rdata_o`=0xA5;
  - `sram_data_oe_o`=0 throughout.
- Back-to-back alternating write/read stream of 16 random addr/data with valid always high:
  - every read returns the last written value;
  - assertion checks hold every cycle: no we&&oe, no oe&&data_oe, cs low ≥1 cycle between accesses;
  - request inputs toggled while busy have no effect.
- Reset asserted in the second W_PULSE cycle → cs, we and data_oe drop immediately, no `rsp_valid_o`. Next read of another address completes normally.
- Parameter sweep WR_PULSE_CYCLES=1, RD_ACCESS_CYCLES=4:
  - write occupancy is 4 cycles;
  - read `rsp_valid_o` at T+6.
